// File: rtl/operand_forward_ctrl_pkg.sv
// rtl/operand_forward_ctrl_pkg.sv - shared select, state and tag definitions for operand forwarding
package operand_forward_ctrl_pkg;

    localparam logic [1:0] SEL_REG = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_ALU = 2'b10;
    localparam logic [1:0] SEL_IMM = 2'b11;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_e;

    // Tag control bits; the destination register travels alongside as a REG_ADDR_W vector.
    typedef struct packed {
        logic valid;
        logic regwrite;
        logic memread;
    } tag_ctl_t;

    localparam tag_ctl_t TAG_BUBBLE = '0;

    // The youngest producer wins when both in-flight stages write the same register.
    function automatic logic [1:0] fwd_pick(input logic ex_hit, input logic mem_hit);
        if (ex_hit)       return SEL_ALU;
        else if (mem_hit) return SEL_WB;
        else              return SEL_REG;
    endfunction

endpackage

// File: rtl/operand_forward_ctrl_if.sv
// rtl/operand_forward_ctrl_if.sv - ID-stage inputs and forwarding/stall outputs
interface operand_forward_ctrl_if #(
    parameter int REG_ADDR_W = 5
) ();
    logic                  id_valid_i;
    logic [REG_ADDR_W-1:0] id_rs_i;
    logic [REG_ADDR_W-1:0] id_rt_i;
    logic                  id_use_rt_i;
    logic                  id_alusrc_i;
    logic [REG_ADDR_W-1:0] id_dst_i;
    logic                  id_regwrite_i;
    logic                  id_memread_i;
    logic                  flush_i;
    logic [1:0]            fwdA_sel_o;
    logic [1:0]            fwdB_sel_o;
    logic                  stall_o;

    modport master (
        output id_valid_i, id_rs_i, id_rt_i, id_use_rt_i, id_alusrc_i,
               id_dst_i, id_regwrite_i, id_memread_i, flush_i,
        input  fwdA_sel_o, fwdB_sel_o, stall_o
    );

    modport slave (
        input  id_valid_i, id_rs_i, id_rt_i, id_use_rt_i, id_alusrc_i,
               id_dst_i, id_regwrite_i, id_memread_i, flush_i,
        output fwdA_sel_o, fwdB_sel_o, stall_o
    );
endinterface

// File: rtl/operand_forward_ctrl_fwd_match.sv
// rtl/operand_forward_ctrl_fwd_match.sv - one tag-versus-source register compare
module fwd_match #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  tag_valid,
    input  logic                  tag_regwrite,
    input  logic [REG_ADDR_W-1:0] tag_dst,
    input  logic [REG_ADDR_W-1:0] src,
    output logic                  match
);
    // Register 0 is hard-wired, so a write to it never produces forwardable data.
    assign match = tag_valid && tag_regwrite && (tag_dst == src) && (src != '0);
endmodule

// File: rtl/operand_forward_ctrl.sv
// rtl/operand_forward_ctrl.sv - EX/MEM tag tracking, forwarding selects and load-use stall
module operand_forward_ctrl
    import operand_forward_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    operand_forward_ctrl_if.slave  bus
);
    tag_ctl_t              ex_ctl_q, ex_ctl_d, mem_ctl_q, mem_ctl_d;
    logic [REG_ADDR_W-1:0] ex_dst_q, ex_dst_d, mem_dst_q, mem_dst_d;
    logic [1:0]            sel_a_q, sel_a_d, sel_b_q, sel_b_d;
    state_e                state_q, state_d;
    logic                  ex_rs_hit, ex_rt_hit, mem_rs_hit, mem_rt_hit;
    logic                  stall;

    fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_ex_rs (
        .tag_valid(ex_ctl_q.valid), .tag_regwrite(ex_ctl_q.regwrite),
        .tag_dst(ex_dst_q), .src(bus.id_rs_i), .match(ex_rs_hit));
    fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_ex_rt (
        .tag_valid(ex_ctl_q.valid), .tag_regwrite(ex_ctl_q.regwrite),
        .tag_dst(ex_dst_q), .src(bus.id_rt_i), .match(ex_rt_hit));
    fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_mem_rs (
        .tag_valid(mem_ctl_q.valid), .tag_regwrite(mem_ctl_q.regwrite),
        .tag_dst(mem_dst_q), .src(bus.id_rs_i), .match(mem_rs_hit));
    fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_mem_rt (
        .tag_valid(mem_ctl_q.valid), .tag_regwrite(mem_ctl_q.regwrite),
        .tag_dst(mem_dst_q), .src(bus.id_rt_i), .match(mem_rt_hit));

    always_comb begin
        // Only a load in EX can starve the consumer; the STALL state blocks a repeat for the same load.
        stall = (state_q == ST_RUN) && ex_ctl_q.memread
             && (ex_rs_hit || (ex_rt_hit && bus.id_use_rt_i))
             && bus.id_valid_i && !bus.flush_i;

        mem_ctl_d = ex_ctl_q;
        mem_dst_d = ex_dst_q;
        ex_ctl_d  = TAG_BUBBLE;
        ex_dst_d  = '0;
        sel_a_d   = SEL_REG;
        sel_b_d   = SEL_REG;

        if (!stall && !bus.flush_i) begin
            if (bus.id_valid_i) begin
                ex_ctl_d.valid    = 1'b1;
                ex_ctl_d.regwrite = bus.id_regwrite_i;
                ex_ctl_d.memread  = bus.id_memread_i;
                ex_dst_d          = bus.id_dst_i;
            end
            sel_a_d = fwd_pick(ex_rs_hit, mem_rs_hit);
            sel_b_d = bus.id_alusrc_i ? SEL_IMM : fwd_pick(ex_rt_hit, mem_rt_hit);
        end

        state_d = state_q;
        case (state_q)
            ST_RUN:   if (stall) state_d = ST_STALL;
            ST_STALL: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_ctl_q  <= TAG_BUBBLE;
            mem_ctl_q <= TAG_BUBBLE;
            ex_dst_q  <= '0;
            mem_dst_q <= '0;
            sel_a_q   <= SEL_REG;
            sel_b_q   <= SEL_REG;
            state_q   <= ST_RUN;
        end else begin
            ex_ctl_q  <= ex_ctl_d;
            mem_ctl_q <= mem_ctl_d;
            ex_dst_q  <= ex_dst_d;
            mem_dst_q <= mem_dst_d;
            sel_a_q   <= sel_a_d;
            sel_b_q   <= sel_b_d;
            state_q   <= state_d;
        end
    end

    assign bus.fwdA_sel_o = sel_a_q;
    assign bus.fwdB_sel_o = sel_b_q;
    assign bus.stall_o    = stall;

endmodule

// File: tb/tb_operand_forward_ctrl.sv
// tb/tb_operand_forward_ctrl.sv - self-checking bench for operand_forward_ctrl
module tb_operand_forward_ctrl;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int   checks = 0;
    int   failures = 0;

    operand_forward_ctrl_if #(.REG_ADDR_W(5)) bus ();

    operand_forward_ctrl #(.REG_ADDR_W(5)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    // Reference: the instructions in flight, index 0 = EX (youngest), 1 = MEM.
    typedef struct {
        bit v;
        bit rw;
        bit mr;
        int dst;
    } ins_t;

    ins_t inflight[2];
    logic       got_stall, exp_stall;
    logic [1:0] got_a, exp_a, got_b, exp_b;

    function automatic logic [1:0] ref_source(input int src);
        if (src == 0) return 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (inflight[i].v && inflight[i].rw && inflight[i].dst == src)
                return (i == 0) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    function automatic bit ref_needs_stall(input bit v, input int rs, input int rt,
                                           input bit use_rt, input bit flush);
        bit load_in_ex;
        load_in_ex = inflight[0].v && inflight[0].rw && inflight[0].mr;
        if (!v || flush || !load_in_ex) return 1'b0;
        if (rs != 0 && inflight[0].dst == rs) return 1'b1;
        if (use_rt && rt != 0 && inflight[0].dst == rt) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 2; i++) inflight[i] = '{v:0, rw:0, mr:0, dst:0};
    endtask

    task automatic step(input bit v, input int rs, input int rt, input bit use_rt,
                        input bit alusrc, input int dst, input bit rw, input bit mr,
                        input bit flush);
        @(negedge clk_i);
        bus.id_valid_i    = v;
        bus.id_rs_i       = rs[4:0];
        bus.id_rt_i       = rt[4:0];
        bus.id_use_rt_i   = use_rt;
        bus.id_alusrc_i   = alusrc;
        bus.id_dst_i      = dst[4:0];
        bus.id_regwrite_i = rw;
        bus.id_memread_i  = mr;
        bus.flush_i       = flush;
        #1;
        got_stall = bus.stall_o;
        exp_stall = ref_needs_stall(v, rs, rt, use_rt, flush);
        if (flush || exp_stall) begin
            exp_a = 2'b00;
            exp_b = 2'b00;
        end else begin
            exp_a = ref_source(rs);
            exp_b = alusrc ? 2'b11 : ref_source(rt);
        end
        @(posedge clk_i);
        #1;
        got_a = bus.fwdA_sel_o;
        got_b = bus.fwdB_sel_o;
        inflight[1] = inflight[0];
        if (!v || flush || exp_stall) inflight[0] = '{v:0, rw:0, mr:0, dst:0};
        else                          inflight[0] = '{v:1, rw:rw, mr:mr, dst:dst};
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        bus.id_valid_i = 0; bus.id_rs_i = 0; bus.id_rt_i = 0; bus.id_use_rt_i = 0;
        bus.id_alusrc_i = 0; bus.id_dst_i = 0; bus.id_regwrite_i = 0;
        bus.id_memread_i = 0; bus.flush_i = 0;
        clear_model();
        rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        checks++; if (bus.stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus.stall_o); end
        checks++; if (bus.fwdA_sel_o !== 2'b00) begin failures++; $display("FAIL reset_sel_a got=%b exp=00", bus.fwdA_sel_o); end
        checks++; if (bus.fwdB_sel_o !== 2'b00) begin failures++; $display("FAIL reset_sel_b got=%b exp=00", bus.fwdB_sel_o); end
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic test_back_to_back();
        step(1, 1, 2, 1, 0, 3, 1, 0, 0);
        step(1, 3, 4, 1, 0, 6, 1, 0, 0);
        checks++; if (got_stall !== 1'b0) begin failures++; $display("FAIL b2b_stall got=%b exp=0", got_stall); end
        checks++; if (got_a !== 2'b10) begin failures++; $display("FAIL b2b_sel_a got=%b exp=10", got_a); end
        idle(); idle();
    endtask

    task automatic test_gap();
        step(1, 1, 2, 1, 0, 5, 1, 0, 0);
        step(1, 7, 9, 1, 0, 12, 1, 0, 0);
        step(1, 1, 5, 1, 0, 13, 1, 0, 0);
        checks++; if (got_b !== 2'b01) begin failures++; $display("FAIL gap_sel_b got=%b exp=01", got_b); end
        idle(); idle();
    endtask

    task automatic test_load_use();
        step(1, 2, 0, 0, 1, 8, 1, 1, 0);
        step(1, 8, 1, 1, 0, 14, 1, 0, 0);
        checks++; if (got_stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b exp=1", got_stall); end
        checks++; if (got_a !== 2'b00 || got_b !== 2'b00) begin failures++; $display("FAIL lu_bubble_sel got=%b/%b exp=00/00", got_a, got_b); end
        step(1, 8, 1, 1, 0, 14, 1, 0, 0);
        checks++; if (got_stall !== 1'b0) begin failures++; $display("FAIL lu_stall_once got=%b exp=0", got_stall); end
        checks++; if (got_a !== 2'b01) begin failures++; $display("FAIL lu_post_sel_a got=%b exp=01", got_a); end
        idle(); idle();
    endtask

    task automatic test_reg_zero();
        step(1, 1, 2, 1, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0, 4, 1, 0, 0);
        checks++; if (got_a !== 2'b00 || got_b !== 2'b00) begin failures++; $display("FAIL r0_sel got=%b/%b exp=00/00", got_a, got_b); end
        idle(); idle();
    endtask

    task automatic test_immediate();
        step(1, 1, 2, 1, 0, 4, 1, 0, 0);
        step(1, 1, 4, 1, 1, 6, 1, 0, 0);
        checks++; if (got_b !== 2'b11) begin failures++; $display("FAIL imm_sel_b got=%b exp=11", got_b); end
        idle(); idle();
    endtask

    task automatic test_same_dst();
        step(1, 1, 2, 1, 0, 7, 1, 0, 0);
        step(1, 1, 2, 1, 0, 7, 1, 0, 0);
        step(1, 7, 7, 1, 0, 3, 1, 0, 0);
        checks++; if (got_a !== 2'b10 || got_b !== 2'b10) begin failures++; $display("FAIL samedst_sel got=%b/%b exp=10/10", got_a, got_b); end
        idle(); idle();
    endtask

    task automatic test_flush_load_use();
        step(1, 1, 0, 0, 1, 9, 1, 1, 0);
        step(1, 9, 9, 1, 0, 4, 1, 0, 1);
        checks++; if (got_stall !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", got_stall); end
        checks++; if (got_a !== 2'b00 || got_b !== 2'b00) begin failures++; $display("FAIL flush_sel got=%b/%b exp=00/00", got_a, got_b); end
        idle(); idle();
    endtask

    task automatic test_reset_mid_stall();
        step(1, 1, 2, 1, 0, 11, 1, 0, 0);
        step(1, 11, 0, 0, 1, 10, 1, 1, 0);
        checks++; if (got_a !== 2'b10) begin failures++; $display("FAIL rms_pre_sel_a got=%b exp=10", got_a); end
        @(negedge clk_i);
        bus.id_valid_i = 1; bus.id_rs_i = 5'd10; bus.id_rt_i = 5'd10; bus.id_use_rt_i = 1;
        bus.id_alusrc_i = 0; bus.id_dst_i = 5'd12; bus.id_regwrite_i = 1;
        bus.id_memread_i = 0; bus.flush_i = 0;
        #1;
        checks++; if (bus.stall_o !== 1'b1) begin failures++; $display("FAIL rms_stall got=%b exp=1", bus.stall_o); end
        #1 rst_i = 1'b0;
        #1;
        checks++; if (bus.stall_o !== 1'b0 || bus.fwdA_sel_o !== 2'b00 || bus.fwdB_sel_o !== 2'b00) begin
            failures++;
            $display("FAIL rms_in_reset got=%b/%b/%b exp=0/00/00", bus.stall_o, bus.fwdA_sel_o, bus.fwdB_sel_o);
        end
        clear_model();
        @(negedge clk_i);
        rst_i = 1'b1;
        step(1, 10, 10, 1, 0, 12, 1, 0, 0);
        checks++; if (got_stall !== 1'b0 || got_a !== 2'b00 || got_b !== 2'b00) begin
            failures++;
            $display("FAIL rms_after got=%b/%b/%b exp=0/00/00", got_stall, got_a, got_b);
        end
        idle(); idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 1), $urandom_range(0, 3) == 0, $urandom_range(0, 3),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
            checks++; if (got_stall !== exp_stall) begin failures++; $display("FAIL rand_stall n=%0d got=%b exp=%b", n, got_stall, exp_stall); end
            checks++; if (got_a !== exp_a) begin failures++; $display("FAIL rand_sel_a n=%0d got=%b exp=%b", n, got_a, exp_a); end
            checks++; if (got_b !== exp_b) begin failures++; $display("FAIL rand_sel_b n=%0d got=%b exp=%b", n, got_b, exp_b); end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gap();
        test_load_use();
        test_reg_zero();
        test_immediate();
        test_same_dst();
        test_flush_load_use();
        test_reset_mid_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/operand_forward_ctrl.md
OPERAND_FORWARD_CTRL -- requirements
Module: operand_forward_ctrl

Interface
REQ-001 Parameter REG_ADDR_W, default 5: register-address width.
REQ-002 Clock and reset: the block SHALL have one clock, clk_i, and an asynchronous, active-low reset, rst_i.
REQ-003 clk_i  input  1  clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  asynchronous active-low reset.
REQ-005 id_valid_i  input  1  ID stage holds a real instruction.
REQ-006 id_rs_i  input  REG_ADDR_W  ID source register A.
REQ-007 id_rt_i  input  REG_ADDR_W  ID source register B.
REQ-008 id_use_rt_i  input  1  instruction reads rt as a register operand.
REQ-009 id_alusrc_i  input  1  operand B is the immediate.
REQ-010 id_dst_i  input  REG_ADDR_W  ID destination register, already resolved (rd/rt/31).
REQ-011 id_regwrite_i  input  1  ID instruction writes the register file.
REQ-012 id_memread_i  input  1  ID instruction is a load.
REQ-013 flush_i  input  1  branch taken; squash the instruction entering EX.
REQ-014 fwdA_sel_o  output  2  select for the operand-A 4:1 mux: 00 regfile, 01 MEM/WB data, 10 EX/MEM ALU result, 11 unused.
REQ-015 fwdB_sel_o  output  2  select for the operand-B 4:1 mux: as fwdA_sel_o, plus 11 = immediate.
REQ-016 stall_o  output  1  hold PC and IF/ID; insert a bubble into EX.

Function
REQ-017 Tracking registers: the block SHALL hold two tag registers, ex_tag and mem_tag, each {valid, regwrite, memread, dst}, mirroring the instructions in EX and MEM.
REQ-018 Tag advance: on each edge, mem_tag SHALL take ex_tag and ex_tag SHALL take the ID fields.
REQ-019 Bubble: ex_tag SHALL take a bubble (all fields 0) when stall_o=1, flush_i=1, or id_valid_i=0.
REQ-020 Tag match: a tag SHALL match a source register only when valid=1, regwrite=1, dst equals the source, and the source is not 0.
REQ-021 Select encoding: the selects SHALL be registered and be valid during the cycle the consumer sits in EX.
REQ-022 Select A priority: fwdA_sel_o SHALL load 10 if ex_tag matches id_rs_i, else 01 if mem_tag matches, else 00.
REQ-023 Select B priority: fwdB_sel_o SHALL load 11 if id_alusrc_i=1, else the REQ-022 priority applied to id_rt_i.
REQ-024 Forwarding scope: no WB-stage compare SHALL be made, because the register file is write-first.
REQ-025 Load-use stall: stall_o SHALL be combinational and equal 1 when ex_tag.memread=1, ex_tag matches id_rs_i (or id_rt_i with id_use_rt_i=1), id_valid_i=1 and flush_i=0.
REQ-026 Stall state machine: states are RUN and STALL.
  - RUN to STALL when stall_o=1.
  - STALL to RUN unconditionally after one cycle.
  - stall_o SHALL NOT assert for two consecutive cycles for the same load.
REQ-027 Stall select load: during a stall cycle, the selects SHALL load 00.
REQ-028 Post-stall select: on the cycle after a stall, the re-evaluated consumer SHALL receive 01 from the load in mem_tag.
REQ-029 Flush precedence: flush_i SHALL win over stall.
  - ex_tag takes a bubble.
  - Both selects load 00.
  - The state machine returns to RUN.
REQ-030 Same-destination conflict: when ex_tag and mem_tag both match, select 10 SHALL be used (youngest data wins).

Reset
REQ-031 While rst_i=0, the block SHALL immediately clear ex_tag, mem_tag, fwdA_sel_o and fwdB_sel_o to 0, and the state machine SHALL enter RUN.
REQ-032 stall_o SHALL read 0 during reset.
REQ-033 A reset asserted mid-stall SHALL abandon the stall, and no stale forwarding SHALL occur after release.

Structure
REQ-034 A shared package SHALL hold:
  - the select encodings (SEL_REG=00, SEL_WB=01, SEL_ALU=10, SEL_IMM=11);
  - the state encodings RUN/STALL;
  - the tag field layout.
REQ-035 One sub-module, fwd_match, SHALL compute the REQ-020 compare and be instantiated four times.

Verification
REQ-036 Back-to-back dependency: add r3 is followed by sub using r3 as rs -> fwdA_sel_o=10 in sub's EX cycle, and stall_o stays 0.
REQ-037 Gap of one instruction: producer r5, one independent instruction, then a consumer reading rt=r5 -> fwdB_sel_o=01.
REQ-038 Load-use: lw r8 followed by add reading rs=r8 -> stall_o=1 for exactly one cycle, selects 00 in the bubble cycle, then fwdA_sel_o=01.
REQ-039 Register $0: producer dst=0 followed by a consumer reading r0 -> selects 00.
REQ-040 Immediate operand: id_alusrc_i=1 with a matching rt -> fwdB_sel_o=11.
REQ-041 Flush during load-use: flush_i=1 in the same cycle as a load-use condition -> stall_o=0, selects 00.
REQ-042 Reset mid-stall: rst_i low during a stall -> all outputs 0 immediately, and after release the next consumer sees 00.
